vram_port_arbiter: RTL and testbench

- Shares the single-port text-mode VRAM BRAM between two requesters: the display fetch path, which reads glyph/attribute words for the colour mapper, and the AXI register-bus side (CPU writes and reads of character cells and palette).
- The display path has absolute priority and is never stalled.
- The bus side uses a valid/ready request channel and a valid/ready response channel, and is served in cycles the display does not claim.
- The block sits between the AXI slave logic and the VRAM BRAM instance, and also feeds the display fetch/colour-mapper pipeline.

---
 rtl/vram_arb_pkg.sv | 24 ++
 rtl/vram_tag_pipe.sv | 31 +++
 rtl/vram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM port arbiter.
// Arbiter states, requester ownership tags and limits.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RSP,
    WR_RSP
  } arb_state_t;

  typedef enum logic {
    OWN_DISP,
    OWN_BUS
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/vram_tag_pipe.sv
// Delay line of {valid, owner} tags.
// Tags line up with BRAM read data RD_LAT cycles later.
import vram_arb_pkg::*;

module vram_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_tag [RD_LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '{valid: 1'b0, owner: OWN_DISP};
      end
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_tag = r_tag[RD_LAT-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads win every cycle,
// bus requests use the leftover cycles via valid/ready.
import vram_arb_pkg::*;

module vram_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int VRAM_WORDS = 1201,
  parameter int RD_LAT     = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_disp_req,
  input  logic [ADDR_W-1:0]   i_disp_addr,
  output logic                o_disp_rvalid,
  output logic [DATA_W-1:0]   o_disp_rdata,
  input  logic                i_bus_req_valid,
  output logic                o_bus_req_ready,
  input  logic                i_bus_we,
  input  logic [ADDR_W-1:0]   i_bus_addr,
  input  logic [DATA_W-1:0]   i_bus_wdata,
  input  logic [DATA_W/8-1:0] i_bus_wstrb,
  output logic                o_bus_rsp_valid,
  input  logic                i_bus_rsp_ready,
  output logic [DATA_W-1:0]   o_bus_rdata,
  output logic                o_mem_en,
  output logic [DATA_W/8-1:0] o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [15:0]         o_max_wait
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_ready;
  logic              w_acc;
  logic              w_in_rng;
  logic              w_bus_hit;
  logic              w_disp_hit;
  tag_t              w_tag_in;
  tag_t              w_tag_out;
  logic [15:0]       r_wait;
  logic [15:0]       r_max;
  logic              r_disp_rvalid;
  logic [DATA_W-1:0] r_disp_rdata;
  logic [DATA_W-1:0] r_bus_rdata;

  assign w_acc    = w_ready && i_bus_req_valid;
  assign w_in_rng = 32'(i_bus_addr) < 32'(VRAM_WORDS);

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_disp_req) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_disp_addr;
    end else if (w_acc && w_in_rng) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_bus_we ? i_bus_wstrb : STRB_W'(0);
      o_mem_addr  = i_bus_addr;
      o_mem_wdata = i_bus_wdata;
    end
  end

  // Owner travels with each read so shared rdata is routed correctly
  assign w_tag_in.valid = i_disp_req ||
                          (w_acc && w_in_rng && !i_bus_we);
  assign w_tag_in.owner = i_disp_req ? OWN_DISP : OWN_BUS;

  vram_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_tag(w_tag_in),
    .o_tag(w_tag_out)
  );

  assign w_bus_hit  = w_tag_out.valid &&
                      (w_tag_out.owner == OWN_BUS);
  assign w_disp_hit = w_tag_out.valid &&
                      (w_tag_out.owner == OWN_DISP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (i_bus_we)      w_next = WR_RSP;
          else if (w_in_rng) w_next = RD_WAIT;
          else               w_next = RD_RSP;
        end
      end
      RD_WAIT: if (w_bus_hit) w_next = RD_RSP;
      RD_RSP:  if (i_bus_rsp_ready) w_next = IDLE;
      WR_RSP:  if (i_bus_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready         = (r_state == IDLE) && !i_disp_req;
    o_bus_rsp_valid = (r_state == RD_RSP) ||
                      (r_state == WR_RSP);
  end

  assign o_bus_req_ready = w_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp_rvalid <= 1'b0;
      r_disp_rdata  <= '0;
      r_bus_rdata   <= '0;
    end else begin
      r_disp_rvalid <= w_disp_hit;
      if (w_disp_hit) r_disp_rdata <= i_mem_rdata;
      if (w_acc && (i_bus_we || !w_in_rng))
        r_bus_rdata <= '0;
      else if (w_bus_hit)
        r_bus_rdata <= i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait <= '0;
      r_max  <= '0;
    end else if (w_acc) begin
      r_wait <= '0;
      if (r_wait > r_max) r_max <= r_wait;
    end else if (i_bus_req_valid && r_wait != 16'hFFFF) begin
      r_wait <= r_wait + 16'd1;
    end
  end

  assign o_disp_rvalid = r_disp_rvalid;
  assign o_disp_rdata  = r_disp_rdata;
  assign o_bus_rdata   = r_bus_rdata;
  assign o_max_wait    = r_max;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a BRAM model.
// Expected responses are queued at issue and checked by monitors.
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [10:0] disp_addr = '0;
  logic        disp_rvalid;
  logic [31:0] disp_rdata;
  logic        bus_req_valid = 1'b0;
  logic        bus_req_ready;
  logic        bus_we = 1'b0;
  logic [10:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_wstrb = '0;
  logic        bus_rsp_valid;
  logic        bus_rsp_ready = 1'b1;
  logic [31:0] bus_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] max_wait;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } dexp_t;

  logic [31:0] mem [0:2047];
  logic [31:0] bq[$];
  dexp_t       dq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          oor_hits = 0;
  int          waited;
  int          lat;

  always #5 clk = ~clk;

  vram_port_arbiter dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_disp_req(disp_req),
    .i_disp_addr(disp_addr),
    .o_disp_rvalid(disp_rvalid),
    .o_disp_rdata(disp_rdata),
    .i_bus_req_valid(bus_req_valid),
    .o_bus_req_ready(bus_req_ready),
    .i_bus_we(bus_we),
    .i_bus_addr(bus_addr),
    .i_bus_wdata(bus_wdata),
    .i_bus_wstrb(bus_wstrb),
    .o_bus_rsp_valid(bus_rsp_valid),
    .i_bus_rsp_ready(bus_rsp_ready),
    .o_bus_rdata(bus_rdata),
    .o_mem_en(mem_en),
    .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_max_wait(max_wait)
  );

  // BRAM model, RD_LAT = 1
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en && mem_addr == 11'h4B1) oor_hits++;
      if (bus_rsp_valid && bus_rsp_ready) begin
        if (bq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("bus_rdata", bus_rdata, bq.pop_front());
      end
      if (disp_rvalid) begin
        if (dq.size() == 0) begin
          chk("unexpected_disp", 32'd1, 32'd0);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          chk("disp_rdata", disp_rdata, e.data);
          chk("disp_lat", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  task automatic bus_op(input logic we, input logic [10:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp,
                        output int w, output int l);
    @(posedge clk); #1;
    bus_req_valid = 1'b1;
    bus_we = we; bus_addr = a; bus_wdata = d; bus_wstrb = s;
    bq.push_back(exp);
    w = 0;
    l = 0;
    forever begin
      @(negedge clk);
      if (bus_req_ready) break;
      w++;
      if (w > 100) break;
    end
    if (w > 100) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus_req_valid = 1'b0;
      void'(bq.pop_back());
      return;
    end
    @(posedge clk); #1;
    bus_req_valid = 1'b0;
    do begin
      @(negedge clk);
      l++;
    end while (!bus_rsp_valid && l < 50);
    if (!bus_rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    int w, l;
    bus_op(1'b1, a, d, s, 32'h0, w, l);
  endtask

  task automatic disp_rd(input logic [10:0] a, input logic [31:0] e);
    dexp_t x;
    disp_req = 1'b1;
    disp_addr = a;
    x.data = e;
    x.cyc = cyc;
    dq.push_back(x);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    chk("rst_disp_rdata", disp_rdata, 32'd0);
    chk("rst_rsp_valid", 32'(bus_rsp_valid), 32'd0);
    chk("rst_bus_rdata", bus_rdata, 32'd0);
    chk("rst_max_wait", 32'(max_wait), 32'd0);
    chk("rst_ready", 32'(bus_req_ready), 32'd1);

    bus_op(1'b1, 11'h005, 32'hDEADBEEF, 4'hF, 32'h0, waited, lat);
    chk("wr_lat", 32'(lat), 32'd1);
    bus_op(1'b0, 11'h005, 32'h0, 4'h0, 32'hDEADBEEF, waited, lat);
    chk("rd_lat", 32'(lat), 32'd2);

    wr(11'h010, 32'h11223344, 4'hF);
    wr(11'h010, 32'hAABBCCDD, 4'h2);
    bus_op(1'b0, 11'h010, 32'h0, 4'h0, 32'h1122CC44, waited, lat);

    for (int i = 0; i < 5; i++) wr(11'(i), 32'hD0000000 + i, 4'hF);
    for (int i = 0; i < 10; i++)
      wr(11'h020 + 11'(i), 32'hC0000000 + i, 4'hF);
    wr(11'h100, 32'h0000ABCD, 4'hF);
    chk("max_wait_idle", 32'(max_wait), 32'd0);

    fork
      bus_op(1'b0, 11'h005, 32'h0, 4'h0, 32'hDEADBEEF, waited, lat);
      begin
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          disp_rd(11'h020 + 11'(i), 32'hC0000000 + i);
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
      end
    join
    chk("contend_waited", 32'(waited), 32'd10);
    chk("contend_max_wait", 32'(max_wait), 32'd10);

    fork
      bus_op(1'b0, 11'h100, 32'h0, 4'h0, 32'h0000ABCD, waited, lat);
      begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          disp_rd(11'(i), 32'hD0000000 + i);
          @(posedge clk); #1;
          disp_req = 1'b0;
        end
      end
    join

    wr(11'h4B1, 32'h12345678, 4'hF);
    bus_op(1'b0, 11'h4B1, 32'h0, 4'h0, 32'h0, waited, lat);
    chk("oor_mem_en", 32'(oor_hits), 32'd0);

    @(posedge clk); #1;
    bus_req_valid = 1'b1; bus_we = 1'b0; bus_addr = 11'h005;
    @(negedge clk);
    chk("rst_rd_ready", 32'(bus_req_ready), 32'd1);
    @(posedge clk); #1;
    bus_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(bus_rsp_valid), 32'd0);
    chk("midrst_max_wait", 32'(max_wait), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(bus_req_ready), 32'd1);
    bus_op(1'b0, 11'h005, 32'h0, 4'h0, 32'hDEADBEEF, waited, lat);

    repeat (5) @(negedge clk);
    chk("bus_q_drained", 32'(bq.size()), 32'd0);
    chk("disp_q_drained", 32'(dq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
